// File: rtl/fn_unit_arbiter.sv
// Round-robin front end that lets NUM_REQ callers share one pipelined function unit.
// Results return in issue order, and a tag FIFO sends each one back to the caller that issued it.
module fn_unit_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ARG_W     = 32,
  parameter int RES_W     = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ARG_W-1:0]       req_arg,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [RES_W-1:0]               rsp_data,
  output logic                           fu_req_valid,
  input  logic                           fu_req_ready,
  output logic [ARG_W-1:0]               fu_req_arg,
  input  logic                           fu_rsp_valid,
  output logic                           fu_rsp_ready,
  input  logic [RES_W-1:0]               fu_rsp_data,
  output logic [$clog2(MAX_OUTST+1)-1:0] outstanding,
  output logic                           err_unexpected
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTST+1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST-1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ-1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] locked_idx_q, locked_idx_d;
  logic [IDX_W-1:0] tag_q [MAX_OUTST];
  logic [IDX_W-1:0] tag_d [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] grant, cand, head;
  logic             can_issue, issue, pop, fifo_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Scan downward so that the lowest offset from rr_ptr is the last one to win.
  always_comb begin
    grant = lock_q ? locked_idx_q : rr_ptr_q;
    cand  = '0;
    if (!lock_q) begin
      for (int k = NUM_REQ-1; k >= 0; k--) begin
        cand = (int'(rr_ptr_q) + k >= NUM_REQ) ? IDX_W'(int'(rr_ptr_q) + k - NUM_REQ)
                                               : IDX_W'(int'(rr_ptr_q) + k);
        if (req_valid[cand]) grant = cand;
      end
    end
  end

  assign can_issue    = (count_q < CNT_MAX);
  assign fu_req_valid = can_issue & (lock_q | (|req_valid));
  assign issue        = fu_req_valid & fu_req_ready;
  assign req_ready    = issue ? (NUM_REQ'(1) << grant) : '0;
  assign fu_req_arg   = req_arg[grant*ARG_W +: ARG_W];

  // Count mirrors FIFO occupancy exactly, so it doubles as the empty flag.
  assign fifo_empty   = (count_q == '0);
  assign head         = tag_q[rd_ptr_q];
  assign rsp_valid    = (!fifo_empty && fu_rsp_valid) ? (NUM_REQ'(1) << head) : '0;
  assign rsp_data     = fu_rsp_data;
  assign fu_rsp_ready = fifo_empty | rsp_ready[head];
  assign pop          = !fifo_empty & fu_rsp_valid & rsp_ready[head];

  assign outstanding    = count_q;
  assign err_unexpected = err_q;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_d        = err_q | (fifo_empty & fu_rsp_valid);
    if (fu_req_valid && !fu_req_ready) begin
      lock_d       = 1'b1;
      locked_idx_d = grant;
    end
    if (issue) begin
      lock_d          = 1'b0;
      rr_ptr_d        = (grant == IDX_LAST) ? '0 : grant + 1'b1;
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({issue, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      for (int i = 0; i < MAX_OUTST; i++) tag_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fn_unit_arbiter.sv
// Directed bench for fn_unit_arbiter: the stimulus queues the expected results,
// and a negedge monitor compares every result the DUT presents.
module tb_fn_unit_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int RW = 32;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*AW-1:0]   req_arg;
  logic [RW-1:0]     rsp_data, fu_rsp_data;
  logic              fu_req_valid, fu_req_ready, fu_rsp_valid, fu_rsp_ready;
  logic [AW-1:0]     fu_req_arg;
  logic [$clog2(MO+1)-1:0] outstanding;
  logic              err_unexpected;

  always #5 clk = ~clk;

  fn_unit_arbiter #(.NUM_REQ(N), .ARG_W(AW), .RES_W(RW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_arg(req_arg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .fu_req_valid(fu_req_valid), .fu_req_ready(fu_req_ready), .fu_req_arg(fu_req_arg),
    .fu_rsp_valid(fu_rsp_valid), .fu_rsp_ready(fu_rsp_ready), .fu_rsp_data(fu_rsp_data),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  typedef struct packed {
    logic [N-1:0]  onehot;
    logic [RW-1:0] data;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [RW-1:0] d);
    exp_t e;
    e.onehot = N'(1) << idx;
    e.data   = d;
    expq.push_back(e);
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask
  task automatic set_arg(input int i, input logic [AW-1:0] v); req_arg[i*AW +: AW] = v; endtask

  task automatic do_reset();
    chk("sb_drained", 64'(expq.size()), 0);
    rst_n = 1'b0;
    expq.delete();
    cyc();
    rst_n = 1'b1;
  endtask

  // Checks each presented result against the scoreboard head and pops it on handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      if (expq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 0);
      else begin
        chk("rsp_valid", 64'(rsp_valid), 64'(expq[0].onehot));
        chk("rsp_data", 64'(rsp_data), 64'(expq[0].data));
        if ((rsp_valid & rsp_ready) != '0) void'(expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_arg = '0; rsp_ready = '1;
    fu_req_ready = 1'b1; fu_rsp_valid = 1'b0; fu_rsp_data = '0;
    smp();
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_fu_req_valid", 64'(fu_req_valid), 0);
    chk("rst_fu_rsp_ready", 64'(fu_rsp_ready), 1);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_err", 64'(err_unexpected), 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Single call from caller 2, result three cycles later
    req_valid = 4'b0100; set_arg(2, 'h15);
    smp();
    chk("single_fu_valid", 64'(fu_req_valid), 1);
    chk("single_fu_arg", 64'(fu_req_arg), 'h15);
    chk("single_req_ready", 64'(req_ready), 4'b0100);
    chk("single_cnt0", 64'(outstanding), 0);
    push(2, 'h2A);
    cyc(); req_valid = '0;
    smp(); chk("single_cnt1", 64'(outstanding), 1);
    cyc(); cyc();
    fu_rsp_valid = 1'b1; fu_rsp_data = 'h2A;
    smp();
    chk("single_fu_rsp_ready", 64'(fu_rsp_ready), 1);
    chk("single_cnt_hold", 64'(outstanding), 1);
    cyc(); fu_rsp_valid = 1'b0;
    smp(); chk("single_cnt_end", 64'(outstanding), 0);
    cyc();
    do_reset();

    // Fairness: everyone requesting, one result returned per cycle
    req_valid = '1;
    for (int i = 0; i < N; i++) set_arg(i, AW'(i));
    for (int k = 0; k < 6; k++) begin
      fu_rsp_valid = (k > 0);
      fu_rsp_data  = RW'('h100 + ((k + 3) % 4));
      smp();
      chk("fair_grant", 64'(req_ready), 64'(N'(1) << (k % 4)));
      chk("fair_arg", 64'(fu_req_arg), 64'(k % 4));
      push(k % 4, RW'('h100 + (k % 4)));
      cyc();
    end
    req_valid = '0; fu_rsp_valid = 1'b1; fu_rsp_data = 'h101;
    smp(); cyc();
    fu_rsp_valid = 1'b0;
    smp(); chk("fair_cnt_end", 64'(outstanding), 0);
    cyc();

    // Stall lock: caller 1 held while caller 0 joins
    req_valid = 4'b0010; set_arg(1, 'h11); set_arg(0, 'h10); fu_req_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s == 1) req_valid = 4'b0011;
      smp();
      chk("stall_fu_valid", 64'(fu_req_valid), 1);
      chk("stall_arg", 64'(fu_req_arg), 'h11);
      chk("stall_ready", 64'(req_ready), 0);
      cyc();
    end
    fu_req_ready = 1'b1;
    smp();
    chk("stall_release_ready", 64'(req_ready), 4'b0010);
    chk("stall_release_arg", 64'(fu_req_arg), 'h11);
    push(1, 'h211);
    cyc(); req_valid = 4'b0001;
    smp();
    chk("stall_next_ready", 64'(req_ready), 4'b0001);
    chk("stall_next_arg", 64'(fu_req_arg), 'h10);
    push(0, 'h210);
    cyc(); req_valid = '0; fu_rsp_valid = 1'b1; fu_rsp_data = 'h211;
    smp(); cyc(); fu_rsp_data = 'h210;
    smp(); cyc(); fu_rsp_valid = 1'b0;
    smp(); chk("stall_cnt_end", 64'(outstanding), 0);
    cyc();

    // Full: four calls in flight, nothing returned
    req_valid = '1;
    for (int i = 0; i < N; i++) set_arg(i, AW'('h30 + i));
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("full_cnt_ramp", 64'(outstanding), 64'(k));
      chk("full_grant", 64'(req_ready), 64'(N'(1) << ((1 + k) % 4)));
      push((1 + k) % 4, RW'('h130 + ((1 + k) % 4)));
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      smp();
      chk("full_ready", 64'(req_ready), 0);
      chk("full_fu_valid", 64'(fu_req_valid), 0);
      chk("full_cnt", 64'(outstanding), 4);
      cyc();
    end
    fu_rsp_valid = 1'b1; fu_rsp_data = 'h131;
    smp();
    chk("full_pop_ready", 64'(req_ready), 0);
    chk("full_pop_cnt", 64'(outstanding), 4);
    cyc(); fu_rsp_data = 'h132;
    smp();
    chk("full_fifth_ready", 64'(req_ready), 4'b0010);
    chk("full_fifth_cnt", 64'(outstanding), 3);
    push(1, 'h131);
    cyc(); fu_rsp_valid = 1'b0; req_valid = '0;
    smp(); chk("full_swap_cnt", 64'(outstanding), 3);

    // Result backpressure on head caller 3
    cyc(); fu_rsp_valid = 1'b1; fu_rsp_data = 'h133; rsp_ready = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("bp_fu_rsp_ready", 64'(fu_rsp_ready), 0);
      chk("bp_cnt", 64'(outstanding), 3);
      cyc();
    end
    rsp_ready = '1;
    smp(); cyc(); fu_rsp_data = 'h130;
    smp(); cyc(); fu_rsp_data = 'h131;
    smp(); cyc(); fu_rsp_valid = 1'b0;
    smp(); chk("bp_cnt_end", 64'(outstanding), 0);

    // Stray result with nothing in flight
    cyc(); fu_rsp_valid = 1'b1; fu_rsp_data = 'hBAD;
    smp();
    chk("err_rsp_valid", 64'(rsp_valid), 0);
    chk("err_fu_rsp_ready", 64'(fu_rsp_ready), 1);
    cyc(); fu_rsp_valid = 1'b0;
    smp(); chk("err_set", 64'(err_unexpected), 1);
    cyc(); cyc();
    smp(); chk("err_sticky", 64'(err_unexpected), 1);

    // Reset with two calls in flight and a lock held
    cyc(); req_valid = 4'b0011; set_arg(0, 'hA0); set_arg(1, 'hA1);
    smp(); cyc();
    smp(); cyc();
    req_valid = 4'b0100; set_arg(2, 'hA2); fu_req_ready = 1'b0;
    smp();
    chk("mid_cnt", 64'(outstanding), 2);
    chk("mid_lock_arg", 64'(fu_req_arg), 'hA2);
    cyc();
    req_valid = 4'b0001; rst_n = 1'b0;
    #1;
    chk("mid_rst_err", 64'(err_unexpected), 0);
    chk("mid_rst_cnt", 64'(outstanding), 0);
    chk("mid_rst_lock", 64'(fu_req_arg), 'hA0);
    chk("mid_rst_ready", 64'(req_ready), 0);
    cyc();
    rst_n = 1'b1; req_valid = '0; fu_req_ready = 1'b1;
    smp(); chk("post_rst_cnt", 64'(outstanding), 0);
    cyc(); fu_rsp_valid = 1'b1; fu_rsp_data = 'h2A;
    smp(); chk("post_rst_rsp_valid", 64'(rsp_valid), 0);
    cyc(); fu_rsp_valid = 1'b0;
    smp(); chk("post_rst_err", 64'(err_unexpected), 1);

    chk("sb_final_drained", 64'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fn_unit_arbiter.md
# fn_unit_arbiter

Shares a single pipelined function-evaluation unit among NUM_REQ callers, so several call sites can invoke one instance of a shared function without duplicating its logic. Round-robin arbitration on the call side, in-order tag tracking for up to MAX_OUTST in-flight calls, and routing of each result back to its caller. Sits between the caller blocks and the shared function unit. Adds no cycles of latency on either path.

## Interface
- NUM_REQ, 4, number of callers (2..8)
- ARG_W, 32, call argument width
- RES_W, 32, result width
- MAX_OUTST, 4, maximum calls issued but not yet answered (1..16)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-caller call request
- req_ready  out  NUM_REQ  per-caller call accepted
- req_arg  in  NUM_REQ*ARG_W  per-caller argument; caller i at bits [i*ARG_W +: ARG_W]
- rsp_valid  out  NUM_REQ  one-hot result valid
- rsp_ready  in  NUM_REQ  per-caller result accept
- rsp_data  out  RES_W  result, shared by all callers
- fu_req_valid  out  1  call issue to function unit
- fu_req_ready  in  1  function unit accepts call
- fu_req_arg  out  ARG_W  argument of granted caller
- fu_rsp_valid  in  1  function unit result valid; results return in issue order
- fu_rsp_ready  out  1  result accept toward function unit
- fu_rsp_data  in  RES_W  function unit result
- outstanding  out  clog2(MAX_OUTST+1)  in-flight call count
- err_unexpected  out  1  sticky; result received with nothing in flight

## Operation
- State: rr_ptr (next-priority caller), lock flag plus locked_idx, tag FIFO of caller indices (depth MAX_OUTST), count, err flag.
- can_issue = (count < MAX_OUTST). Count is registered, so a same-cycle pop does not free a slot.
- Grant, when unlocked: first caller with req_valid set, scanning from rr_ptr upward with wrap. When locked: locked_idx.
- fu_req_valid = can_issue and (locked or any req_valid).
- fu_req_arg = argument of the granted caller.
- req_ready[g] = fu_req_ready and can_issue, for the granted g only. All other bits are 0.
- Stall (fu_req_valid=1, fu_req_ready=0):
  - Set lock and locked_idx=g.
  - The grant and argument stay stable until the handshake.
  - Callers must hold req_valid and req_arg until req_ready.
- Issue handshake:
  - Push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Clear lock.
- Result path, FIFO non-empty:
  - head = FIFO head.
  - rsp_valid[head] = fu_rsp_valid.
  - rsp_data = fu_rsp_data.
  - fu_rsp_ready = rsp_ready[head].
  - Handshake pops the FIFO.
- Result path, FIFO empty:
  - rsp_valid = 0 and fu_rsp_ready = 1, so the stray result is drained.
  - If fu_rsp_valid=1, set err_unexpected. It stays set until reset.
- Count update:
  - +1 on issue, -1 on pop.
  - Issue and pop in the same cycle leave count unchanged.
  - Count never exceeds MAX_OUTST and never underflows.
- outstanding = count.

## Timing
- Reset values (async assert, sync release):
  - rr_ptr=0, lock=0, count=0, FIFO empty, err_unexpected=0.
  - Outputs: req_ready=0, rsp_valid=0, fu_req_valid=0 (unless a req_valid is high combinationally), fu_rsp_ready=1, outstanding=0.
- req to fu_req: combinational, 0 cycles.
- fu_rsp to rsp: combinational, 0 cycles. Total added latency is 0.
- A new caller becomes eligible in the cycle after the previous grant's handshake (rr_ptr update).
- Back-to-back issues, one per cycle, while count < MAX_OUTST.
- Reset mid-operation discards all in-flight tags. Results arriving afterwards are treated as unexpected.

## Test plan
- Single call: caller 2 sends arg 0x15. The unit accepts immediately and returns 0x2A three cycles later.
  - Required: fu_req_arg=0x15, req_ready=0b0100 in the same cycle, rsp_valid=0b0100 with rsp_data=0x2A.
  - Required: outstanding goes 0→1→0.
- Fairness: all four callers request continuously with fu_req_ready=1.
  - Required grant order 0,1,2,3,0,1.
  - Each caller receives its own result, matched by argument = caller index.
- Stall lock: caller 1 is granted while fu_req_ready=0 for 5 cycles, and caller 0 asserts req_valid during the stall.
  - Required: grant stays on 1 and fu_req_arg stays stable.
  - Required: caller 0 is granted only after caller 1's handshake.
- Full: MAX_OUTST=4 with no results returned.
  - Required: the 5th request sees req_ready=0 and outstanding=4.
  - Required: on the first result pop, the next cycle accepts the 5th request.
  - Required: in a cycle with simultaneous issue and pop at count=3, count stays 3.
- Result backpressure: rsp_ready of the head caller is low for 4 cycles.
  - Required: fu_rsp_ready=0 for those cycles, and the FIFO head is unchanged.
- Error and reset: fu_rsp_valid pulses with count=0.
  - Required: err_unexpected=1 stays set, and rsp_valid=0.
  - Required: asserting rst_n low with 2 calls in flight clears err_unexpected, outstanding and lock immediately.
